fu_burst_driver: RTL and testbench

Streaming front/back end for the temporally programmed functional unit (TP-FU). It pops operand words from a host-side first-word-fall-through (FWFT) FIFO and stages them. It then drives them into the FU as one contiguous `valid` burst, which the FU requires because its register-file write pointer resets whenever `valid` drops. Finally it captures the FU's `dout`/`dout_v` result pulses and writes them to a host-side output FIFO. It sits between the Xillybus FIFOs and the FU.

---
 rtl/fu_burst_driver.sv | 190 +++++++++++++++++++
 tb/tb_fu_burst_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_burst_driver.sv
// fu_burst_driver
//   Streaming front/back end for the temporally programmed functional unit.
//   Pops BURST_LEN operand words from a FWFT input FIFO, replays them to the
//   FU as one gap-free `fu_valid` burst (the FU regfile write pointer resets
//   whenever valid drops), captures RES_LEN result strobes, and pushes the
//   results to the output FIFO.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   in_data/in_empty/in_rd_en      FWFT input FIFO side (rd_en combinational)
//   fu_din/fu_valid                registered operand stream to the FU
//   fu_dout/fu_dout_v              FU result and strobe (FU cannot stall)
//   out_data/out_wr_en/out_full    output FIFO side (wr_en combinational)
//   busy            high unless idle in FILL with nothing staged
//   timeout_err     sticky watchdog flag (cleared only by reset)
//
// Build option
//   FU_DRIVER_TIMEOUT_EN: when defined, an idle watchdog in WAIT aborts after
//   TIMEOUT strobe-free cycles, raises timeout_err and flushes the partial
//   result set. When undefined, WAIT waits forever and timeout_err is 0.

module fu_burst_driver #(
    parameter int BURST_LEN = 4,
    parameter int RES_LEN   = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_empty,
    output logic        in_rd_en,
    output logic [15:0] fu_din,
    output logic        fu_valid,
    input  logic [15:0] fu_dout,
    input  logic        fu_dout_v,
    output logic [15:0] out_data,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic        busy,
    output logic        timeout_err
);

    localparam int MAXL = (BURST_LEN > RES_LEN) ? BURST_LEN : RES_LEN;
    localparam int CW   = $clog2(MAXL) + 1;
    localparam int OAW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int RAW  = (RES_LEN > 1) ? $clog2(RES_LEN) : 1;
    localparam logic [CW-1:0] OLAST = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] RLAST = CW'(RES_LEN - 1);

    typedef enum logic [1:0] {S_FILL, S_SEND, S_WAIT, S_FLUSH} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [15:0]   r_obuf [2**OAW];
    logic [15:0]   r_rbuf [2**RAW];
    logic [15:0]   r_fu_din;
    logic          r_fu_valid;
    logic          w_pop, w_push, w_cap, w_timeout;
    logic [CW-1:0] w_flush_last;   // index of the last result FLUSH writes

`ifdef FU_DRIVER_TIMEOUT_EN
    localparam int IW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [IW-1:0] ILAST = IW'(TIMEOUT - 1);

    logic [IW-1:0] r_idle;
    logic [CW-1:0] r_flen;
    logic          r_tmo_err;

    // Fires on the TIMEOUT-th consecutive strobe-free WAIT cycle.
    assign w_timeout = (r_state == S_WAIT) && !fu_dout_v && (r_idle == ILAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle    <= '0;
            r_flen    <= RLAST;
            r_tmo_err <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && !fu_dout_v && !w_timeout)
                r_idle <= r_idle + 1'b1;
            else
                r_idle <= '0;
            // Flush length is frozen while flushing; an abort flushes only
            // the results captured so far.
            if (r_state != S_FLUSH)
                r_flen <= w_timeout ? (r_cnt - 1'b1) : RLAST;
            if (w_timeout)
                r_tmo_err <= 1'b1;
        end
    end

    assign w_flush_last = r_flen;
    assign timeout_err  = r_tmo_err;
`else
    assign w_timeout    = 1'b0;
    assign w_flush_last = RLAST;
    assign timeout_err  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            S_FILL: begin
                if (!in_empty) begin
                    w_pop = 1'b1;
                    if (r_cnt == OLAST) begin
                        w_state_nxt = S_SEND;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (r_cnt == OLAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (fu_dout_v) begin
                    w_cap = 1'b1;
                    if (r_cnt == RLAST) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    // Nothing captured means nothing to flush.
                    w_state_nxt = (r_cnt == '0) ? S_FILL : S_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FLUSH: begin
                if (!out_full) begin
                    w_push = 1'b1;
                    if (r_cnt == w_flush_last) begin
                        w_state_nxt = S_FILL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FILL;
            r_cnt      <= '0;
            r_fu_valid <= 1'b0;
            r_fu_din   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fu_valid <= (r_state == S_SEND);
            if (r_state == S_SEND)
                r_fu_din <= r_obuf[r_cnt[OAW-1:0]];
        end
    end

    // Staging buffers carry no reset; stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_pop)
            r_obuf[r_cnt[OAW-1:0]] <= in_data;
        if (w_cap)
            r_rbuf[r_cnt[RAW-1:0]] <= fu_dout;
    end

    // FIFO strobes are gated by reset so nothing is popped or pushed while
    // the state is being held.
    assign in_rd_en  = w_pop & rst;
    assign out_wr_en = w_push & rst;
    assign out_data  = r_rbuf[r_cnt[RAW-1:0]];
    assign fu_din    = r_fu_din;
    assign fu_valid  = r_fu_valid;
    assign busy      = !((r_state == S_FILL) && (r_cnt == '0));

endmodule

// File: tb/tb_fu_burst_driver.sv
// tb_fu_burst_driver
//   Scoreboard bench for fu_burst_driver (BURST_LEN=4, RES_LEN=4, TIMEOUT=16).
//   Reference: the driver is a transparent ordered pipe. Every word written
//   into the input FIFO must appear on fu_din in order, in gap-free runs of
//   BURST_LEN; every result the FU stub emits must reach the output FIFO in
//   order. Expected words are queued when stimulus is issued; a monitor pops
//   and compares whenever fu_valid or out_wr_en is seen.

module tb_fu_burst_driver;
    localparam int BL  = 4;
    localparam int RL  = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_empty = 1'b1;
    logic        in_rd_en;
    logic [15:0] fu_din;
    logic        fu_valid;
    logic [15:0] fu_dout = '0;
    logic        fu_dout_v = 1'b0;
    logic [15:0] out_data;
    logic        out_wr_en;
    logic        out_full = 1'b0;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    fu_burst_driver #(.BURST_LEN(BL), .RES_LEN(RL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_empty(in_empty), .in_rd_en(in_rd_en),
        .fu_din(fu_din), .fu_valid(fu_valid),
        .fu_dout(fu_dout), .fu_dout_v(fu_dout_v),
        .out_data(out_data), .out_wr_en(out_wr_en), .out_full(out_full),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_fu[$];
    logic [15:0] exp_out[$];

    bit stall_mode = 0, full_rand = 0, abort = 0, stub_busy = 0, stub_fixed = 0;
    int stub_n = RL;
    int pops = 0, writes = 0, cyc = 0, last_cap_cyc = 0, tmo_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_q.push_back(w);
        exp_fu.push_back(w);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_word(16'($urandom));
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (t < 3000 && !(fifo_q.size() == 0 && exp_fu.size() == 0 &&
                             exp_out.size() == 0 && !stub_busy && !busy)) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_complete"}, 32'(t < 3000), 1);
    endtask

    // Input FWFT FIFO model: a pop requested in a cycle retires at its edge.
    initial begin : in_fifo
        bit pend;
        bit tog;
        tog = 0;
        forever begin
            @(negedge clk);
            pend = in_rd_en;
            @(posedge clk); #1;
            if (pend && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            tog = ~tog;
            in_empty = (fifo_q.size() == 0) || (stall_mode && tog);
            in_data  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
        end
    end

    // FU stub: after each burst ends, emit stub_n non-adjacent result pulses.
    initial begin : fu_stub
        bit prev;
        int gap;
        prev = 0;
        forever begin
            @(negedge clk);
            if (prev && !fu_valid && rst && !abort) begin
                stub_busy = 1;
                for (int k = 0; k < stub_n; k++) begin
                    gap = $urandom_range(1, 3);
                    repeat (gap) @(posedge clk);
                    #1;
                    fu_dout   = stub_fixed ? 16'(16'hA1 + k) : 16'($urandom);
                    fu_dout_v = 1'b1;
                    exp_out.push_back(fu_dout);
                    @(posedge clk); #1;
                    fu_dout_v    = 1'b0;
                    last_cap_cyc = cyc;
                end
                stub_busy = 0;
            end
            prev = fu_valid;
        end
    end

    initial begin : full_gen
        forever begin
            @(posedge clk); #1;
            if (full_rand) out_full = ($urandom % 3 == 0);
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        int run;
        logic [15:0] e;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst || abort) begin
                run = 0;
                if (!rst) check("wr_en_in_reset", 32'(out_wr_en), 0);
            end else begin
                if (fu_valid) begin
                    if (exp_fu.size() == 0) check("fu_valid_unexpected", 1, 0);
                    else begin
                        e = exp_fu.pop_front();
                        check("fu_din", 32'(fu_din), 32'(e));
                    end
                    run++;
                end else if (run > 0) begin
                    check("burst_len", run, BL);
                    run = 0;
                end
                if (in_empty) check("rd_en_while_empty", 32'(in_rd_en), 0);
                if (out_full) check("wr_en_while_full", 32'(out_wr_en), 0);
                if (out_wr_en) begin
                    writes++;
                    if (exp_out.size() == 0) check("out_wr_unexpected", 1, 0);
                    else begin
                        e = exp_out.pop_front();
                        check("out_data", 32'(out_data), 32'(e));
                    end
                end
                if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int w0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fu_valid", 32'(fu_valid), 0);
        check("rst_fu_din", 32'(fu_din), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_out_wr_en", 32'(out_wr_en), 0);
        check("rst_in_rd_en", 32'(in_rd_en), 0);

        // Directed burst, FIFO pre-filled before reset release.
        stub_fixed = 1;
        push_word(16'h0003); push_word(16'h0007);
        push_word(16'h0002); push_word(16'h0005);
        repeat (2) @(posedge clk);
        #1;
        pops = 0;
        rst  = 1'b1;
        n = 0;
        while (!fu_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_valid_latency", n, BL + 1);
        wait_done("directed");
        check("pop_count", pops, BL);
        stub_fixed = 0;

        // Stray strobe while idle in FILL must be dropped.
        @(posedge clk); #1;
        fu_dout = 16'hDEAD; fu_dout_v = 1'b1;
        @(posedge clk); #1;
        fu_dout_v = 1'b0;
        check("busy_after_stray", 32'(busy), 0);

        // Input stalls every other cycle during FILL.
        stall_mode = 1;
        push_rand(BL);
        wait_done("stall");
        stall_mode = 0;

        // Output FIFO full for 10 cycles during FLUSH.
        push_rand(BL);
        n = 0;
        while (!stub_busy && n < 200) begin @(posedge clk); #1; n++; end
        out_full = 1'b1;
        while (stub_busy && n < 400) begin @(posedge clk); #1; n++; end
        check("full_reached_flush", 32'(n < 400), 1);
        repeat (10) @(posedge clk);
        #1;
        check("held_results", exp_out.size(), RL);
        out_full = 1'b0;
        wait_done("full_hold");

        // Randomized back-to-back traffic.
        stall_mode = 1'($urandom % 2);
        full_rand  = 1;
        push_rand(BL * 12);
        wait_done("random");
        full_rand  = 0;
        stall_mode = 0;
        @(posedge clk); #1;
        out_full = 1'b0;

        // Reset during the 2nd SEND cycle.
        push_rand(BL);
        n = 0;
        while (!fu_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("reset_burst_seen", 32'(n < 100), 1);
        @(posedge clk); #1;
        abort = 1;
        rst   = 1'b0;
        #1;
        check("valid_drop_on_reset", 32'(fu_valid), 0);
        fifo_q.delete(); exp_fu.delete(); exp_out.delete();
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b1;
        abort = 0;
        push_rand(BL);
        wait_done("after_reset");

`ifdef FU_DRIVER_TIMEOUT_EN
        // FU returns only 2 of 4 results; watchdog must abort and flush 2.
        stub_n  = 2;
        tmo_cyc = -1;
        w0      = writes;
        push_rand(BL);
        wait_done("timeout");
        check("timeout_err_set", 32'(timeout_err), 1);
        check("timeout_flushed", writes - w0, 2);
        check("timeout_idle_cycles", tmo_cyc - last_cap_cyc, TMO);
        stub_n = RL;
        push_rand(BL);
        wait_done("post_timeout");
        check("timeout_err_sticky", 32'(timeout_err), 1);
`else
        w0 = writes;
        check("writes_progressed", 32'(w0 > 0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
